nvdla_rdma_dmaif_mux: RTL
=========================

// Module: nvdla_rdma_dmaif_mux
// PURPOSE
//  Multi-channel read-DMA interface. Arbitrates NUM_CH client read-request streams onto the MCIF
//  (ram_type=1) and CVIF (ram_type=0) read ports, tags each request, and routes in-order responses
//  back to the issuing channel. Aggregates per-channel latency-FIFO credit pops into per-interface counts.
//  Sits between RDMA engines (SDP/PDP/CDP) and the memory-interface read ports.
// PARAMETERS
//  NUM_CH     4   client channels (1..8)
//  REQ_W      47  request payload width (addr+size)
//  RSP_W      65  response payload width (data+mask)
//  TAG_DEPTH  8   per-interface outstanding-request tag FIFO depth (power of 2)
//  MAX_OUTS   4   per-channel outstanding-request limit
// PORTS
//  nvdla_core_clk               in   1             core clock
//  nvdla_core_rst               in   1             asynchronous, active-high reset
//  dma_rd_req_pd                in   NUM_CH*REQ_W  per-channel request payload (ch i at [i*REQ_W+:REQ_W])
//  dma_rd_req_ram_type          in   NUM_CH        per-channel target: 1=MCIF, 0=CVIF
//  dma_rd_req_vld / _rdy        in/out NUM_CH      per-channel request handshake
//  dma_rd_rsp_pd                out  RSP_W         shared response payload
//  dma_rd_rsp_vld / _rdy        out/in NUM_CH      per-channel response handshake (one-hot vld)
//  dma_rd_cdt_lat_fifo_pop      in   NUM_CH        per-channel latency-FIFO pop pulse
//  dma_rd_cdt_ram_type          in   NUM_CH        interface credited by each pop
//  {mcif,cvif}_rd_req_pd        out  REQ_W         request payload to interface
//  {mcif,cvif}_rd_req_valid     out  1 ; {mcif,cvif}_rd_req_ready in 1
//  {mcif,cvif}_rd_rsp_pd        in   RSP_W ; _valid in 1 ; _ready out 1
//  {mcif,cvif}_rd_cdt_pop_cnt   out  $clog2(NUM_CH+1)  registered credit-pop count
// BEHAVIOUR
//  - Reset: all valids, pop counts, outstanding counters, tag FIFOs, RR pointers = 0; payloads = 0.
//  - Channel i eligible when req_vld[i] & outs_cnt[i]<MAX_OUTS & target tag FIFO not full & target
//    output register empty or draining this cycle. One RR arbiter per interface; pointer advances
//    to grant+1 on grant only. dma_rd_req_rdy[i] = grant[i] (combinational, no vld->rdy loop on rdy side).
//  - Granted request is registered into the interface output register: 1-cycle req latency;
//    valid held, pd stable until ready. Tag (channel id) pushed into that interface's tag FIFO
//    on grant. Back-to-back grants sustain 1 req/cycle per interface.
//  - Responses return in order per interface; tag FIFO head selects destination channel.
//    Single shared response bus: when both interfaces valid, RR between MCIF/CVIF (toggle on
//    accept); otherwise serve the valid one. Combinational pass-through: dma_rd_rsp_vld[head]=1,
//    {if}_rd_rsp_ready = selected & dma_rd_rsp_rdy[head]. Tag popped on accepted beat.
//  - One response beat per request. outs_cnt[i]: +1 on grant, -1 on accepted rsp; both same cycle
//    -> unchanged. Never exceeds MAX_OUTS; never underflows.
//  - Response valid with empty tag FIFO is a protocol error: ready held 0, assertion fires.
//  - Credit pops: each cycle, count pops per ram_type; registered to {if}_rd_cdt_pop_cnt (1-cycle
//    latency). All NUM_CH pops in one cycle -> count = NUM_CH, no loss.
//  - Reset asserted mid-transaction: outstanding state discarded; no output valid until deassert.
// STRUCTURE
//  - Shared package nvdla_dmaif_pkg: REQ_W/RSP_W defaults, RAM_TYPE_MCIF=1/CVIF=0 constants,
//    rr_next() function for round-robin pointer update.
//  - Sub-module nvdla_dmaif_tag_fifo (flop-based, TAG_DEPTH x $clog2(NUM_CH), full/empty flags),
//    instantiated twice (MCIF, CVIF). Arbiters, counters, response mux stay in top.
// TESTING
//  1 Reset: rst=1 mid-burst -> all valids 0, pop counts 0; after release ch0 req accepted normally.
//  2 Round robin: ch0..ch3 vld, all ram_type=1, mcif ready=1 -> grants 0,1,2,3,0 on successive cycles.
//  3 Split routing: ch0 ram_type=1, ch1 ram_type=0 same cycle -> both granted; mcif/cvif req_valid
//    high next cycle with respective pd.
//  4 Outstanding limit: ch2 issues 4 reqs, no rsp -> 5th blocked (rdy=0); one rsp accepted ->
//    grant resumes next cycle; simultaneous grant+rsp leaves outs_cnt=4.
//  5 Response ordering/backpressure: mcif tags {1,3}, both if rsp valid, dma_rd_rsp_rdy[1]=0 ->
//    mcif_rd_rsp_ready=0, pd stable; release -> beats to ch1 then ch3, cvif interleaved by RR.
//  6 Credits: pops=4'b1111, cdt_ram_type=4'b0101 -> next cycle mcif_cnt=2, cvif_cnt=2.

Source files
------------

// File: rtl/nvdla_dmaif_pkg.sv
// Shared definitions for the read-DMA interface mux: default payload widths,
// interface select encoding and the round-robin pointer update.
package nvdla_dmaif_pkg;

  localparam int REQ_W_DEF = 47;
  localparam int RSP_W_DEF = 65;

  localparam logic RAM_TYPE_MCIF = 1'b1;
  localparam logic RAM_TYPE_CVIF = 1'b0;

  // Per-interface arrays in the mux are indexed by the ram_type value.
  localparam int IF_MCIF = 1;
  localparam int IF_CVIF = 0;

  function automatic int rr_next(input int grant, input int n);
    return (grant + 1 >= n) ? 0 : grant + 1;
  endfunction

endpackage

// File: rtl/nvdla_rdma_dmaif_mux_if.sv
// Bus bundles for the read-DMA mux: the multi-channel client side and one
// memory-interface read port (instantiated once for MCIF and once for CVIF).
interface nvdla_dmaif_client_if
  import nvdla_dmaif_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int REQ_W  = REQ_W_DEF,
  parameter int RSP_W  = RSP_W_DEF
);
  logic [NUM_CH*REQ_W-1:0] dma_rd_req_pd;
  logic [NUM_CH-1:0]       dma_rd_req_ram_type;
  logic [NUM_CH-1:0]       dma_rd_req_vld;
  logic [NUM_CH-1:0]       dma_rd_req_rdy;
  logic [RSP_W-1:0]        dma_rd_rsp_pd;
  logic [NUM_CH-1:0]       dma_rd_rsp_vld;
  logic [NUM_CH-1:0]       dma_rd_rsp_rdy;
  logic [NUM_CH-1:0]       dma_rd_cdt_lat_fifo_pop;
  logic [NUM_CH-1:0]       dma_rd_cdt_ram_type;

  modport master (
    output dma_rd_req_pd, dma_rd_req_ram_type, dma_rd_req_vld, dma_rd_rsp_rdy,
           dma_rd_cdt_lat_fifo_pop, dma_rd_cdt_ram_type,
    input  dma_rd_req_rdy, dma_rd_rsp_pd, dma_rd_rsp_vld
  );

  modport slave (
    input  dma_rd_req_pd, dma_rd_req_ram_type, dma_rd_req_vld, dma_rd_rsp_rdy,
           dma_rd_cdt_lat_fifo_pop, dma_rd_cdt_ram_type,
    output dma_rd_req_rdy, dma_rd_rsp_pd, dma_rd_rsp_vld
  );
endinterface

interface nvdla_dmaif_mem_if
  import nvdla_dmaif_pkg::*;
#(
  parameter int REQ_W = REQ_W_DEF,
  parameter int RSP_W = RSP_W_DEF,
  parameter int CNT_W = 3
);
  logic [REQ_W-1:0] rd_req_pd;
  logic             rd_req_valid;
  logic             rd_req_ready;
  logic [RSP_W-1:0] rd_rsp_pd;
  logic             rd_rsp_valid;
  logic             rd_rsp_ready;
  logic [CNT_W-1:0] rd_cdt_pop_cnt;

  modport master (
    output rd_req_pd, rd_req_valid, rd_rsp_ready, rd_cdt_pop_cnt,
    input  rd_req_ready, rd_rsp_pd, rd_rsp_valid
  );

  modport slave (
    input  rd_req_pd, rd_req_valid, rd_rsp_ready, rd_cdt_pop_cnt,
    output rd_req_ready, rd_rsp_pd, rd_rsp_valid
  );
endinterface

// File: rtl/nvdla_dmaif_tag_fifo.sv
// Flop-based FIFO of channel tags, one entry per request outstanding on a
// memory interface; the head names the channel owed the next response beat.
module nvdla_dmaif_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_tag,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_tag;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/nvdla_rdma_dmaif_mux.sv
// Read-DMA interface mux: round-robin arbitration of client read requests onto
// MCIF/CVIF, tag-steered in-order response return, and credit-pop aggregation.
module nvdla_rdma_dmaif_mux
  import nvdla_dmaif_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int REQ_W     = REQ_W_DEF,
  parameter int RSP_W     = RSP_W_DEF,
  parameter int TAG_DEPTH = 8,
  parameter int MAX_OUTS  = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  nvdla_dmaif_client_if.slave dma,
  nvdla_dmaif_mem_if.master   mcif,
  nvdla_dmaif_mem_if.master   cvif
);
  localparam int TAG_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W  = $clog2(NUM_CH + 1);
  localparam int OUTS_W = $clog2(MAX_OUTS + 1);

  logic [1:0]        if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [RSP_W-1:0]  if_rsp_pd [2];
  logic [1:0]        tag_full, tag_empty, can_load, gnt_any;
  logic [TAG_W-1:0]  tag_head [2];
  logic [TAG_W-1:0]  gnt_idx [2];
  logic [NUM_CH-1:0] elig [2];
  logic [NUM_CH-1:0] grant [2];
  logic [NUM_CH-1:0] req_gnt, rsp_vld;
  logic [1:0]        rsp_svc;
  logic              rsp_sel, rsp_acc;
  logic [TAG_W-1:0]  rsp_head;

  logic [1:0]        req_vld_q, req_vld_d;
  logic [REQ_W-1:0]  req_pd_q [2];
  logic [REQ_W-1:0]  req_pd_d [2];
  logic [TAG_W-1:0]  ptr_q [2];
  logic [TAG_W-1:0]  ptr_d [2];
  logic [OUTS_W-1:0] outs_q [NUM_CH];
  logic [OUTS_W-1:0] outs_d [NUM_CH];
  logic              rsp_rr_q, rsp_rr_d;
  logic [CNT_W-1:0]  mcif_cnt_q, mcif_cnt_d, cvif_cnt_q, cvif_cnt_d;

  assign if_req_ready      = {mcif.rd_req_ready, cvif.rd_req_ready};
  assign if_rsp_valid      = {mcif.rd_rsp_valid, cvif.rd_rsp_valid};
  assign if_rsp_pd[IF_MCIF] = mcif.rd_rsp_pd;
  assign if_rsp_pd[IF_CVIF] = cvif.rd_rsp_pd;

  // Request arbitration: one round-robin arbiter per interface, scanning from its pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < 2; k++) begin
      can_load[k] = ~req_vld_q[k] | if_req_ready[k];
      elig[k]     = '0;
      grant[k]    = '0;
      gnt_idx[k]  = '0;
      gnt_any[k]  = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        elig[k][i] = dma.dma_rd_req_vld[i] && (int'(dma.dma_rd_req_ram_type[i]) == k) &&
                     (int'(outs_q[i]) < MAX_OUTS) && !tag_full[k] && can_load[k] &&
                     !nvdla_core_rst;
      for (int off = 0; off < NUM_CH; off++) begin
        idx = int'(ptr_q[k]) + off;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!gnt_any[k] && elig[k][idx]) begin
          gnt_any[k]    = 1'b1;
          gnt_idx[k]    = TAG_W'(idx);
          grant[k][idx] = 1'b1;
        end
      end
    end
  end

  assign req_gnt = grant[0] | grant[1];
  assign dma.dma_rd_req_rdy = req_gnt;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      req_vld_d[k] = req_vld_q[k] & ~if_req_ready[k];
      req_pd_d[k]  = req_pd_q[k];
      ptr_d[k]     = ptr_q[k];
      if (gnt_any[k]) begin
        req_vld_d[k] = 1'b1;
        req_pd_d[k]  = dma.dma_rd_req_pd[int'(gnt_idx[k])*REQ_W +: REQ_W];
        ptr_d[k]     = TAG_W'(rr_next(int'(gnt_idx[k]), NUM_CH));
      end
    end
  end

  nvdla_dmaif_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TAG_W)) u_tag_cvif (
    .clk(nvdla_core_clk), .rst(nvdla_core_rst),
    .push(gnt_any[IF_CVIF]), .push_tag(gnt_idx[IF_CVIF]), .pop(if_rsp_ready[IF_CVIF]),
    .full(tag_full[IF_CVIF]), .empty(tag_empty[IF_CVIF]), .head(tag_head[IF_CVIF])
  );

  nvdla_dmaif_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TAG_W)) u_tag_mcif (
    .clk(nvdla_core_clk), .rst(nvdla_core_rst),
    .push(gnt_any[IF_MCIF]), .push_tag(gnt_idx[IF_MCIF]), .pop(if_rsp_ready[IF_MCIF]),
    .full(tag_full[IF_MCIF]), .empty(tag_empty[IF_MCIF]), .head(tag_head[IF_MCIF])
  );

  // Response return: selection ignores client ready so vld never depends on rdy.
  always_comb begin
    rsp_svc      = if_rsp_valid & ~tag_empty;
    rsp_sel      = (rsp_svc == 2'b11) ? rsp_rr_q : rsp_svc[IF_MCIF];
    rsp_head     = tag_head[rsp_sel];
    rsp_vld      = '0;
    if_rsp_ready = '0;
    if (|rsp_svc) begin
      rsp_vld[rsp_head]     = 1'b1;
      if_rsp_ready[rsp_sel] = dma.dma_rd_rsp_rdy[rsp_head];
    end
    rsp_acc  = |if_rsp_ready;
    rsp_rr_d = rsp_acc ? ~rsp_sel : rsp_rr_q;
  end

  assign dma.dma_rd_rsp_vld = rsp_vld;
  assign dma.dma_rd_rsp_pd  = if_rsp_pd[rsp_sel];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      outs_d[i] = outs_q[i];
      case ({req_gnt[i], rsp_acc && (int'(rsp_head) == i)})
        2'b10:   outs_d[i] = outs_q[i] + OUTS_W'(1);
        2'b01:   outs_d[i] = outs_q[i] - OUTS_W'(1);
        default: outs_d[i] = outs_q[i];
      endcase
    end
  end

  always_comb begin
    mcif_cnt_d = '0;
    cvif_cnt_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dma.dma_rd_cdt_lat_fifo_pop[i]) begin
        if (dma.dma_rd_cdt_ram_type[i] == RAM_TYPE_MCIF) mcif_cnt_d = mcif_cnt_d + CNT_W'(1);
        else                                             cvif_cnt_d = cvif_cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      req_vld_q  <= '0;
      rsp_rr_q   <= 1'b0;
      mcif_cnt_q <= '0;
      cvif_cnt_q <= '0;
      for (int k = 0; k < 2; k++) begin
        req_pd_q[k] <= '0;
        ptr_q[k]    <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) outs_q[i] <= '0;
    end else begin
      req_vld_q  <= req_vld_d;
      req_pd_q   <= req_pd_d;
      ptr_q      <= ptr_d;
      outs_q     <= outs_d;
      rsp_rr_q   <= rsp_rr_d;
      mcif_cnt_q <= mcif_cnt_d;
      cvif_cnt_q <= cvif_cnt_d;
    end
  end

  assign mcif.rd_req_valid   = req_vld_q[IF_MCIF];
  assign mcif.rd_req_pd      = req_pd_q[IF_MCIF];
  assign mcif.rd_rsp_ready   = if_rsp_ready[IF_MCIF];
  assign mcif.rd_cdt_pop_cnt = mcif_cnt_q;
  assign cvif.rd_req_valid   = req_vld_q[IF_CVIF];
  assign cvif.rd_req_pd      = req_pd_q[IF_CVIF];
  assign cvif.rd_rsp_ready   = if_rsp_ready[IF_CVIF];
  assign cvif.rd_cdt_pop_cnt = cvif_cnt_q;

  // A response with no outstanding tag has no destination.
  a_mcif_rsp_tag: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(mcif.rd_rsp_valid && tag_empty[IF_MCIF]));
  a_cvif_rsp_tag: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(cvif.rd_rsp_valid && tag_empty[IF_CVIF]));

endmodule
